// File: rtl/spring_pkg.sv
// rtl/spring_pkg.sv - shared FSM state type and saturation helper for the spring force engine
package spring_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int SAT_W = 64;

    // Clamps v into the signed range of a width-bit word; callers keep the low width bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/spring_force_lane.sv
// rtl/spring_force_lane.sv - one axis of the force pipeline: products (S1), shift and saturate (S2)
module spring_force_lane
    import spring_pkg::*;
#(
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int CONST_SIZE    = 8,
    parameter int FRAC_BITS     = 4,
    parameter int FORCE_SIZE    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic signed [CONST_SIZE-1:0]    k,
    input  logic signed [CONST_SIZE-1:0]    b,
    input  logic signed [POSITION_SIZE-1:0] pos,
    input  logic signed [POSITION_SIZE-1:0] ideal,
    input  logic signed [VELOCITY_SIZE-1:0] vel,
    output logic signed [FORCE_SIZE-1:0]    force_val
);

    localparam int D_W   = POSITION_SIZE + 1;
    localparam int KD_W  = CONST_SIZE + D_W;
    localparam int BV_W  = CONST_SIZE + VELOCITY_SIZE;
    localparam int SUM_W = ((KD_W > BV_W) ? KD_W : BV_W) + 1;

    logic signed [D_W-1:0]   d;
    logic signed [KD_W-1:0]  kd;
    logic signed [KD_W-1:0]  kd_q;
    logic signed [BV_W-1:0]  bv;
    logic signed [BV_W-1:0]  bv_q;
    logic signed [SUM_W-1:0] raw;

    // Difference gets one extra bit so extreme positions cannot wrap.
    assign d   = D_W'(ideal) - D_W'(pos);
    assign kd  = KD_W'(k) * KD_W'(d);
    assign bv  = BV_W'(b) * BV_W'(vel);
    assign raw = (SUM_W'(kd_q) - SUM_W'(bv_q)) >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kd_q      <= '0;
            bv_q      <= '0;
            force_val <= '0;
        end else if (en) begin
            kd_q      <= kd;
            bv_q      <= bv;
            force_val <= FORCE_SIZE'(sat_signed(SAT_W'(raw), FORCE_SIZE));
        end
    end

endmodule

// File: rtl/spring_force_engine.sv
// rtl/spring_force_engine.sv - per-node spring/damper force streamer with axle reaction accumulator
module spring_force_engine
    import spring_pkg::*;
#(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int CONST_SIZE    = 8,
    parameter int FRAC_BITS     = 4,
    parameter int FORCE_SIZE    = 16,
    parameter int AXLE_SIZE     = FORCE_SIZE + $clog2(NUM_NODES + 1),
    localparam int IDX_W        = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                                              clk_in,
    input  logic                                              rst_n_in,
    input  logic                                              input_valid,
    input  logic signed [CONST_SIZE-1:0]                      k_in,
    input  logic signed [CONST_SIZE-1:0]                      b_in,
    input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_in,
    input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] ideal_nodes_in,
    input  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] velocities_in,
    output logic                                              busy_out,
    output logic signed [FORCE_SIZE-1:0]                      force_x_out,
    output logic signed [FORCE_SIZE-1:0]                      force_y_out,
    output logic [IDX_W-1:0]                                  force_idx_out,
    output logic                                              force_valid_out,
    input  logic                                              force_ready_in,
    output logic signed [AXLE_SIZE-1:0]                       axle_force_x_out,
    output logic signed [AXLE_SIZE-1:0]                       axle_force_y_out,
    output logic                                              done_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t state, state_next;

    logic signed [CONST_SIZE-1:0]                  k_q, b_q;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  pos_q, ideal_q;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  vel_q;

    logic [IDX_W-1:0] issue_cnt, idx, s1_idx;
    logic             idx_valid, s1_valid;
    logic             accept, issuing, advance, handshake;

    assign handshake = force_valid_out & force_ready_in;
    // A held output beat freezes every stage behind it.
    assign advance   = ~(force_valid_out & ~force_ready_in);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        accept     = 1'b0;
        issuing    = 1'b0;
        case (state)
            IDLE: begin
                if (input_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_out = 1'b1;
                issuing  = advance;
                if (advance && issue_cnt == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (handshake && force_idx_out == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            k_q              <= '0;
            b_q              <= '0;
            pos_q            <= '0;
            ideal_q          <= '0;
            vel_q            <= '0;
            issue_cnt        <= '0;
            idx              <= '0;
            idx_valid        <= 1'b0;
            s1_idx           <= '0;
            s1_valid         <= 1'b0;
            force_idx_out    <= '0;
            force_valid_out  <= 1'b0;
            axle_force_x_out <= '0;
            axle_force_y_out <= '0;
        end else begin
            if (accept) begin
                k_q              <= k_in;
                b_q              <= b_in;
                pos_q            <= nodes_in;
                ideal_q          <= ideal_nodes_in;
                vel_q            <= velocities_in;
                issue_cnt        <= '0;
                axle_force_x_out <= '0;
                axle_force_y_out <= '0;
            end
            if (advance) begin
                idx_valid       <= issuing;
                s1_valid        <= idx_valid;
                s1_idx          <= idx;
                force_valid_out <= s1_valid;
                force_idx_out   <= s1_idx;
                if (issuing) begin
                    idx       <= issue_cnt;
                    issue_cnt <= issue_cnt + IDX_W'(1);
                end
            end
            if (handshake) begin
                axle_force_x_out <= axle_force_x_out - AXLE_SIZE'(force_x_out);
                axle_force_y_out <= axle_force_y_out - AXLE_SIZE'(force_y_out);
            end
        end
    end

    spring_force_lane #(
        .POSITION_SIZE(POSITION_SIZE),
        .VELOCITY_SIZE(VELOCITY_SIZE),
        .CONST_SIZE   (CONST_SIZE),
        .FRAC_BITS    (FRAC_BITS),
        .FORCE_SIZE   (FORCE_SIZE)
    ) lane_x (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .en       (advance),
        .k        (k_q),
        .b        (b_q),
        .pos      (pos_q[0][idx]),
        .ideal    (ideal_q[0][idx]),
        .vel      (vel_q[0][idx]),
        .force_val(force_x_out)
    );

    spring_force_lane #(
        .POSITION_SIZE(POSITION_SIZE),
        .VELOCITY_SIZE(VELOCITY_SIZE),
        .CONST_SIZE   (CONST_SIZE),
        .FRAC_BITS    (FRAC_BITS),
        .FORCE_SIZE   (FORCE_SIZE)
    ) lane_y (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .en       (advance),
        .k        (k_q),
        .b        (b_q),
        .pos      (pos_q[1][idx]),
        .ideal    (ideal_q[1][idx]),
        .vel      (vel_q[1][idx]),
        .force_val(force_y_out)
    );

endmodule

// File: tb/tb_spring_force_engine.sv
// tb/tb_spring_force_engine.sv - scoreboard bench for spring_force_engine
module tb_spring_force_engine;

    localparam int N  = 10;
    localparam int P  = 16;
    localparam int V  = 16;
    localparam int C  = 8;
    localparam int FB = 4;
    localparam int F  = 16;
    localparam int AW = F + $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam longint FMAX = (64'sd1 <<< (F - 1)) - 64'sd1;
    localparam longint FMIN = -FMAX - 64'sd1;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic input_valid = 1'b0;
    logic force_ready_in = 1'b1;
    logic signed [C-1:0] k_in = '0;
    logic signed [C-1:0] b_in = '0;
    logic signed [1:0][N-1:0][P-1:0] nodes_in = '0;
    logic signed [1:0][N-1:0][P-1:0] ideal_nodes_in = '0;
    logic signed [1:0][N-1:0][V-1:0] velocities_in = '0;
    logic busy_out, force_valid_out, done_out;
    logic signed [F-1:0] force_x_out, force_y_out;
    logic [IW-1:0] force_idx_out;
    logic signed [AW-1:0] axle_force_x_out, axle_force_y_out;

    spring_force_engine dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .input_valid     (input_valid),
        .k_in            (k_in),
        .b_in            (b_in),
        .nodes_in        (nodes_in),
        .ideal_nodes_in  (ideal_nodes_in),
        .velocities_in   (velocities_in),
        .busy_out        (busy_out),
        .force_x_out     (force_x_out),
        .force_y_out     (force_y_out),
        .force_idx_out   (force_idx_out),
        .force_valid_out (force_valid_out),
        .force_ready_in  (force_ready_in),
        .axle_force_x_out(axle_force_x_out),
        .axle_force_y_out(axle_force_y_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int     idx;
        longint fx;
        longint fy;
    } beat_t;

    beat_t  exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     beats = 0;
    int     done_cnt = 0;
    longint exp_ax, exp_ay;
    int     fk, fb;
    int     fpos[2][N];
    int     fideal[2][N];
    int     fvel[2][N];
    bit     poke_busy = 1'b0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint model_force(input longint k, input longint b, input longint pos,
                                           input longint ideal, input longint vel);
        longint raw;
        raw = (k * (ideal - pos) - b * vel) >>> FB;
        if (raw > FMAX) return FMAX;
        if (raw < FMIN) return FMIN;
        return raw;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic randomize_frame();
        fk = int'($urandom_range(0, 255)) - 128;
        fb = int'($urandom_range(0, 255)) - 128;
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < N; i++) begin
                fpos[a][i]   = rnd16();
                fideal[a][i] = rnd16();
                fvel[a][i]   = rnd16();
            end
        end
    endtask

    task automatic drive_frame();
        exp_q.delete();
        exp_ax = 0;
        exp_ay = 0;
        beats  = 0;
        for (int i = 0; i < N; i++) begin
            beat_t bt;
            bt.idx = i;
            bt.fx  = model_force(fk, fb, fpos[0][i], fideal[0][i], fvel[0][i]);
            bt.fy  = model_force(fk, fb, fpos[1][i], fideal[1][i], fvel[1][i]);
            exp_q.push_back(bt);
            exp_ax -= bt.fx;
            exp_ay -= bt.fy;
        end
        @(posedge clk_in);
        #1;
        k_in = C'(fk);
        b_in = C'(fb);
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < N; i++) begin
                nodes_in[a][i]       = P'(fpos[a][i]);
                ideal_nodes_in[a][i] = P'(fideal[a][i]);
                velocities_in[a][i]  = V'(fvel[a][i]);
            end
        end
        input_valid = 1'b1;
        @(posedge clk_in);
        #1;
        input_valid    = 1'b0;
        k_in           = ~k_in;
        b_in           = ~b_in;
        nodes_in       = ~nodes_in;
        ideal_nodes_in = ~ideal_nodes_in;
        velocities_in  = ~velocities_in;
    endtask

    task automatic finish_frame(input string name, input int mode, input int exp_done);
        int cyc = 0;
        int first_valid = -1;
        bit seen_done = 1'b0;
        while (cyc < 300 && !seen_done) begin
            if (mode == 1)
                force_ready_in = (cyc < 5) ? 1'b1 : (cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            else
                force_ready_in = 1'b1;
            input_valid = (poke_busy && cyc == 4);
            @(posedge clk_in);
            #1;
            cyc++;
            if (cyc == 1) check_eq({name, "_busy"}, busy_out, 1);
            if (force_valid_out && first_valid < 0) first_valid = cyc;
            if (done_out) seen_done = 1'b1;
        end
        input_valid    = 1'b0;
        force_ready_in = 1'b1;
        check_eq({name, "_done_seen"}, seen_done, 1);
        check_eq({name, "_first_valid"}, first_valid, 3);
        if (exp_done > 0) check_eq({name, "_done_cycle"}, cyc, exp_done);
        check_eq({name, "_busy_at_done"}, busy_out, 0);
        check_eq({name, "_beats"}, beats, N);
        check_eq({name, "_queue_left"}, exp_q.size(), 0);
        check_eq({name, "_axle_x"}, axle_force_x_out, exp_ax);
        check_eq({name, "_axle_y"}, axle_force_y_out, exp_ay);
        @(posedge clk_in);
        #1;
        check_eq({name, "_done_one_cycle"}, done_out, 0);
        check_eq({name, "_axle_x_held"}, axle_force_x_out, exp_ax);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_busy"}, busy_out, 0);
        check_eq({name, "_valid"}, force_valid_out, 0);
        check_eq({name, "_done"}, done_out, 0);
        check_eq({name, "_fx"}, force_x_out, 0);
        check_eq({name, "_fy"}, force_y_out, 0);
        check_eq({name, "_idx"}, force_idx_out, 0);
        check_eq({name, "_axle_x"}, axle_force_x_out, 0);
        check_eq({name, "_axle_y"}, axle_force_y_out, 0);
    endtask

    bit             stalled = 1'b0;
    logic [F-1:0]   held_x, held_y;
    logic [IW-1:0]  held_idx;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (stalled) begin
                check_eq("hold_valid", force_valid_out, 1);
                check_eq("hold_x", force_x_out, longint'($signed(held_x)));
                check_eq("hold_y", force_y_out, longint'($signed(held_y)));
                check_eq("hold_idx", force_idx_out, held_idx);
            end
            stalled  = force_valid_out && !force_ready_in;
            held_x   = force_x_out;
            held_y   = force_y_out;
            held_idx = force_idx_out;
            if (force_valid_out && force_ready_in) begin
                beats++;
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t bt;
                    bt = exp_q.pop_front();
                    check_eq("beat_idx", force_idx_out, bt.idx);
                    check_eq("beat_fx", force_x_out, bt.fx);
                    check_eq("beat_fy", force_y_out, bt.fy);
                end
            end
            if (done_out) done_cnt++;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        int cyc;
        int dcnt;

        #12;
        check_all_zero("reset");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // basic: node0 force (8,-10)
        randomize_frame();
        fk = 16; fb = 8;
        fpos[0][0] = 0;  fpos[1][0] = 0;
        fideal[0][0] = 10; fideal[1][0] = -10;
        fvel[0][0] = 4;  fvel[1][0] = 0;
        drive_frame();
        finish_frame("basic", 0, 13);

        // floor rounding of +/-1/16
        randomize_frame();
        fk = 1; fb = 0;
        fpos[0][0] = 0; fideal[0][0] = -1; fpos[1][0] = 0; fideal[1][0] = 1;
        fpos[0][1] = 0; fideal[0][1] = 1;  fpos[1][1] = 0; fideal[1][1] = -1;
        drive_frame();
        finish_frame("floor", 0, 13);

        // saturation at both rails
        randomize_frame();
        fk = 127; fb = 0;
        fpos[0][0] = -32768; fideal[0][0] = 32767;
        fpos[1][0] = 32767;  fideal[1][0] = -32768;
        fpos[0][1] = 32767;  fideal[0][1] = -32768;
        fpos[1][1] = -32768; fideal[1][1] = 32767;
        drive_frame();
        finish_frame("sat", 0, 13);

        // backpressure: 5 stalled cycles, then random ready
        randomize_frame();
        drive_frame();
        finish_frame("bp", 1, -1);

        // full frame of (1,2) forces with an ignored input_valid while busy
        randomize_frame();
        fk = 16; fb = 0;
        for (int i = 0; i < N; i++) begin
            fpos[0][i] = int'($urandom_range(0, 2000)) - 1000;
            fpos[1][i] = int'($urandom_range(0, 2000)) - 1000;
            fideal[0][i] = fpos[0][i] + 1;
            fideal[1][i] = fpos[1][i] + 2;
        end
        poke_busy = 1'b1;
        drive_frame();
        finish_frame("full", 0, 13);
        poke_busy = 1'b0;
        check_eq("full_axle_x_const", axle_force_x_out, -10);
        check_eq("full_axle_y_const", axle_force_y_out, -20);

        // asynchronous reset after beat 4
        randomize_frame();
        drive_frame();
        cyc = 0;
        while (beats < 5 && cyc < 100) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
        check_eq("rst_reached_beat4", beats >= 5, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("rst_mid");
        dcnt = done_cnt;
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check_eq("rst_no_done", done_cnt, dcnt);
        check_eq("rst_idle_busy", busy_out, 0);

        randomize_frame();
        drive_frame();
        finish_frame("after_rst", 0, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spring_force_engine.md
Name: spring_force_engine

Overview:
Next-generation per-node spring/damper force engine for the soft-body car. It snapshots node positions, ideal (target) positions and velocities, then streams one saturated 2-D force per node through a valid/ready output. It also reports the reaction force on the axle, equal to the negated sum of the node forces. It replaces shift-based constants with signed fixed-point multiplies, adds backpressure, and sizes every width by parameter.

Parameters:
NUM_NODES, 10, number of nodes processed per frame (>=1)
POSITION_SIZE, 16, signed position width
VELOCITY_SIZE, 16, signed velocity width
CONST_SIZE, 8, signed width of k and b
FRAC_BITS, 4, fractional bits of k and b; products are arithmetically shifted right by this amount
FORCE_SIZE, 16, signed per-node force width (saturated)
AXLE_SIZE, FORCE_SIZE+$clog2(NUM_NODES+1), signed axle accumulator width (cannot overflow)

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset, asynchronous, active-low
input_valid  in  1  frame start; accepted only when busy_out=0
k_in  in  CONST_SIZE  signed spring constant, fixed-point
b_in  in  CONST_SIZE  signed damping constant, fixed-point
nodes_in  in  [1:0][NUM_NODES] x POSITION_SIZE  node x/y positions
ideal_nodes_in  in  [1:0][NUM_NODES] x POSITION_SIZE  target x/y positions
velocities_in  in  [1:0][NUM_NODES] x VELOCITY_SIZE  node x/y velocities
busy_out  out  1  high from accept until done_out
force_x_out, force_y_out  out  FORCE_SIZE  current node force
force_idx_out  out  $clog2(NUM_NODES)  node index of current force
force_valid_out  out  1  force beat valid
force_ready_in  in  1  downstream accepts beat
axle_force_x_out, axle_force_y_out  out  AXLE_SIZE  axle reaction force, held until next frame
done_out  out  1  one-cycle pulse when axle outputs are final

Behaviour:
- Reset (asynchronous, rst_n_in=0): all outputs and all state go to 0, and the FSM goes to IDLE. A frame in progress is abandoned; no done_out pulse.
- Accept: input_valid=1 in IDLE latches k, b and all node arrays, clears the axle accumulators and sets busy_out on the next cycle. input_valid while busy is ignored; the latched snapshot is unaffected.
- FSM states: IDLE -> RUN (accept) -> DRAIN (last index issued) -> DONE (last beat handshaken) -> IDLE.
  - DONE lasts exactly one cycle. It drives done_out=1 and clears busy_out.
- Per node i, for each axis: d = ideal - pos, computed at POSITION_SIZE+1 bits.
  - raw = (k*d - b*vel) >>> FRAC_BITS, using full-precision signed products and floor rounding.
  - The force is raw saturated to [-2^(FORCE_SIZE-1), 2^(FORCE_SIZE-1)-1].
- Pipeline: index register -> S1 (registered products) -> S2 (output register).
  - First force_valid_out is asserted 3 cycles after the accept edge.
  - Without backpressure, one beat per cycle; the frame completes at accept + NUM_NODES + 3 cycles (done_out cycle).
- Handshake:
  - A beat transfers when force_valid_out & force_ready_in.
  - While force_valid_out=1 and force_ready_in=0, S2, S1 and the index all hold; outputs are stable and no beat is dropped or duplicated.
  - force_valid_out may not wait for force_ready_in.
- Beat order: beats are emitted in index order 0..NUM_NODES-1, with force_idx_out matching.
- Axle accumulation:
  - axle_force_x/y_out accumulate minus the saturated force of each beat, on its handshake cycle.
  - During a frame they show the running sum; they are final when done_out=1 and hold until the next accept.
- NUM_NODES=1: frame is a single beat; FSM goes RUN -> DRAIN immediately.

Decomposition:
- Shared package spring_pkg: state enum (IDLE, RUN, DRAIN, DONE) and a sat_signed function (width-generic via parameterised helper).
- One natural sub-module, spring_force_lane: S1/S2 math for one axis (d, two multiplies, shift, saturate). It is instantiated twice (x, y) under a common stall enable.

Test Plan:
- Basic: FRAC_BITS=4, k=16 (1.0), b=8 (0.5), node0 pos=(0,0), ideal=(10,-10), vel=(4,0), ready=1 -> beat0 force=(8,-10); beat at accept+3.
- Floor rounding: k=1, b=0, d=-1 -> force -1; d=+1 -> force 0.
- Saturation: FORCE_SIZE=16, k=127, pos=-32768, ideal=32767, b=0 -> force 32767. Mirror case -> -32768. Axle subtracts the saturated values.
- Backpressure: ready low for 5 cycles mid-frame, random toggling after -> all NUM_NODES beats arrive exactly once, in index order, with outputs stable while stalled.
- Full frame: 10 nodes, each force (1,2), ready=1 -> axle=(-10,-20) at done_out, done_out at accept+13. A second input_valid during busy is ignored.
- Reset mid-frame: rst_n_in low after beat 4 -> outputs 0 immediately (asynchronous), no done_out. A new frame after release completes normally.
